// File: rtl/gs_bus_pkg.sv
// Shared widths, register map, request bundle and FSM states
// for the gs_bus_master write path.
package gs_bus_pkg;

  localparam int GS_ADDR_W  = 64;
  localparam int GS_DATA_W  = 32;
  localparam int GS_GPREG_W = 16;
  localparam int SHADOW_N   = 9;

  localparam logic [GS_ADDR_W-1:0] ADDR_MTR_EN     = 64'd0;
  localparam logic [GS_ADDR_W-1:0] ADDR_MTR_DIR    = 64'd1;
  localparam logic [GS_ADDR_W-1:0] ADDR_MTR_SPEED  = 64'd2;
  localparam logic [GS_ADDR_W-1:0] ADDR_MTR_ACCEL  = 64'd3;
  localparam logic [GS_ADDR_W-1:0] ADDR_ENC_CFG    = 64'd4;
  localparam logic [GS_ADDR_W-1:0] ADDR_ADC_CFG    = 64'd5;
  localparam logic [GS_ADDR_W-1:0] ADDR_ADC_GAIN   = 64'd6;
  localparam logic [GS_ADDR_W-1:0] ADDR_DAC_GAIN   = 64'd7;
  localparam logic [GS_ADDR_W-1:0] ADDR_DAC_OFFSET = 64'd8;

  typedef struct packed {
    logic [GS_ADDR_W-1:0]  addr;
    logic [GS_DATA_W-1:0]  data;
    logic [GS_GPREG_W-1:0] gpreg;
  } gs_bus_req_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_GAP
  } gs_state_e;

endpackage

// File: rtl/gs_bus_master_if.sv
// Host request handshake plus outgoing bus write strobe
// of gs_bus_master.
interface gs_bus_master_if #(
  parameter int FIFO_DEPTH = 4
) ();
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic                             req_valid;
  logic                             req_ready;
  logic [gs_bus_pkg::GS_ADDR_W-1:0]  req_addr;
  logic [gs_bus_pkg::GS_DATA_W-1:0]  req_data;
  logic [gs_bus_pkg::GS_GPREG_W-1:0] req_gpreg;
  logic                             bus_valid;
  logic [gs_bus_pkg::GS_ADDR_W-1:0]  bus_addr;
  logic [gs_bus_pkg::GS_DATA_W-1:0]  bus_data;
  logic [gs_bus_pkg::GS_GPREG_W-1:0] bus_gpreg;
  logic [CW-1:0]                    pending;
  logic                             busy;

  modport master (
    input  req_valid, req_addr, req_data, req_gpreg,
    output req_ready, bus_valid, bus_addr, bus_data,
    output bus_gpreg, pending, busy
  );

  modport slave (
    output req_valid, req_addr, req_data, req_gpreg,
    input  req_ready, bus_valid, bus_addr, bus_data,
    input  bus_gpreg, pending, busy
  );

endinterface

// File: rtl/gs_bus_fifo.sv
// Synchronous request queue; push is ignored when full and
// pop when empty, head is read combinationally.
module gs_bus_fifo
  import gs_bus_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  gs_bus_req_t   wdata,
  input  logic          pop,
  output gs_bus_req_t   rdata,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  gs_bus_req_t   mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full    = cnt_q == CW'(DEPTH);
  assign empty   = cnt_q == '0;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    wptr_d = wptr_q + AW'(do_push);
    rptr_d = rptr_q + AW'(do_pop);
    cnt_d  = cnt_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata;
  end

  assign rdata = mem_q[rptr_q];
  assign count = cnt_q;

endmodule

// File: rtl/gs_bus_master.sv
// Queued host writes issued as single-cycle bus strobes with a
// forced idle gap; GS_BUS_SHADOW_EN adds a 9-entry shadow file.
module gs_bus_master
  import gs_bus_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_CYCLES = 1
) (
  input  logic bus_clk,
  input  logic rst,
  gs_bus_master_if.master bif
`ifdef GS_BUS_SHADOW_EN
  ,
  input  logic [3:0]           shadow_addr,
  output logic [GS_DATA_W-1:0] shadow_data
`endif
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  gs_state_e     state_q, state_d;
  logic [3:0]    gap_q, gap_d;
  logic          req_ready_q, req_ready_d;
  logic          bus_valid_q, bus_valid_d;
  gs_bus_req_t   bus_q, bus_d;
  gs_bus_req_t   wr_req, head;
  logic          push, pop;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_cnt, cnt_nxt;

  assign wr_req.addr  = bif.req_addr;
  assign wr_req.data  = bif.req_data;
  assign wr_req.gpreg = bif.req_gpreg;
  assign push = bif.req_valid && req_ready_q && !fifo_full;

  gs_bus_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (bus_clk),
    .rst   (rst),
    .push  (push),
    .wdata (wr_req),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

  // ready is registered from next-cycle occupancy so it never lags full
  assign cnt_nxt     = fifo_cnt + CW'(push) - CW'(pop);
  assign req_ready_d = cnt_nxt != CW'(FIFO_DEPTH);

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    pop     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (GAP_CYCLES > 0) begin
          state_d = ST_GAP;
          gap_d   = 4'(GAP_CYCLES);
        end else if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GAP: begin
        if (gap_q <= 4'd1) begin
          gap_d = '0;
          if (!fifo_empty) begin
            pop     = 1'b1;
            state_d = ST_ISSUE;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          gap_d = gap_q - 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    bus_d       = pop ? head : bus_q;
    bus_valid_d = state_d == ST_ISSUE;
  end

  always_ff @(posedge bus_clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      gap_q       <= '0;
      req_ready_q <= 1'b0;
      bus_valid_q <= 1'b0;
      bus_q       <= '0;
    end else begin
      state_q     <= state_d;
      gap_q       <= gap_d;
      req_ready_q <= req_ready_d;
      bus_valid_q <= bus_valid_d;
      bus_q       <= bus_d;
    end
  end

  assign bif.req_ready = req_ready_q;
  assign bif.bus_valid = bus_valid_q;
  assign bif.bus_addr  = bus_q.addr;
  assign bif.bus_data  = bus_q.data;
  assign bif.bus_gpreg = bus_q.gpreg;
  assign bif.pending   = fifo_cnt;
  assign bif.busy      = (fifo_cnt != '0) || (state_q != ST_IDLE);

`ifdef GS_BUS_SHADOW_EN
  logic [GS_DATA_W-1:0] shadow_q [SHADOW_N];
  logic [GS_DATA_W-1:0] shadow_d [SHADOW_N];

  always_comb begin
    shadow_d = shadow_q;
    if (pop && head.addr < GS_ADDR_W'(SHADOW_N))
      shadow_d[head.addr[3:0]] = head.data;
  end

  always_ff @(posedge bus_clk) begin
    if (rst) begin
      for (int i = 0; i < SHADOW_N; i++) shadow_q[i] <= '0;
    end else begin
      shadow_q <= shadow_d;
    end
  end

  assign shadow_data = (shadow_addr < 4'(SHADOW_N))
                     ? shadow_q[shadow_addr] : '0;
`endif

endmodule
